pattern_checker: RTL and testbench
==================================

Name: pattern_checker

Overview:
- Downstream consumer of the 3-bit repeating pattern stream 001 -> 011 -> 100 -> 010 -> 001 ... and the idle code 000.
- Samples the pattern bus every clock and detects its phase.
- Declares lock after a run of correct consecutive codes.
- Flags and counts sequence errors, and counts completed 4-code frames while locked.
- Used as the on-chip self-check for the pattern generator and for any link that carries its output.

Parameters:
- LOCK_LEN, 4, consecutive correct codes needed to lock. Legal range 2..15.
- MAX_MISS, 2, consecutive mismatches in LOCKED before dropping to HUNT. Legal range 1..7.
- CNT_W, 8, width of err_cnt and frame_cnt.

Ports:
- clk  in  1  rising-edge clock, same domain as the generator.
- rst_n  in  1  reset, asynchronous, active-low.
- q  in  3  pattern bus under check, registered by the upstream stage.
- clr  in  1  synchronous clear of err_cnt and frame_cnt.
- locked  out  1  high while in the LOCKED state.
- phase  out  2  phase of the last sampled legal code: 001=0, 011=1, 100=2, 010=3. Holds its value on 000 or an illegal code.
- err  out  1  one-cycle pulse for each error event.
- err_cnt  out  CNT_W  error events counted, saturating at all-ones.
- frame_cnt  out  CNT_W  completed frames while locked, wrapping.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; locked=0, phase=0, err=0, err_cnt=0, frame_cnt=0. Internal registers cleared: run=0, miss=0, exp=0.
- All outputs are registered. A code sampled at edge N affects the outputs visible after edge N.
- Code classes:
  - idle = 000.
  - legal = 001, 011, 100, 010.
  - illegal = 101, 110, 111.
  - next(p) = (p+1) mod 4; exp holds the expected phase.
- State IDLE:
  - idle: stay.
  - legal: go to HUNT; run=1; exp=next(phase(q)).
  - illegal: err pulse; stay.
- State HUNT:
  - q == code(exp): run+1; exp=next(exp). If the new run == LOCK_LEN, go to LOCKED with miss=0.
  - Other legal code: err pulse; reseed run=1, exp=next(phase(q)).
  - idle: go to IDLE, run=0, no error.
  - illegal: err pulse; go to IDLE.
- State LOCKED:
  - Match: miss=0; exp=next(exp). If the matched code is 010, frame_cnt+1.
  - idle: go to IDLE; locked drops after that edge; no error (clean stop).
  - Legal mismatch or illegal code: err pulse; miss+1; exp=next(exp) (flywheel).
    - If the new miss == MAX_MISS: go to HUNT, reseeded from q if q is legal (run=1), else run=0 with the next legal code reseeding.
- The locking edge itself does not bump frame_cnt. frame_cnt counts only matches made while already in LOCKED.
- err_cnt increments on every err pulse and saturates at 2^CNT_W-1. frame_cnt wraps modulo 2^CNT_W.
- clr=1: err_cnt and frame_cnt go to 0 at that edge; clr wins over a simultaneous increment. State, locked, phase and err are not affected by clr.
- rst_n asserted mid-frame: everything returns to reset values immediately. After release, checking restarts in IDLE.
- Latency from the first legal code to locked=1: LOCK_LEN edges (4 by default).

Test Plan:
- Reset, then q=000 for 3 cycles, then 001,011,100,010,001,011,100,010 -> locked rises after the 4th code (010). After the second 010, frame_cnt=1, err_cnt=0, phase=3.
- Lock, then inject a single 111 in place of 100 and continue the correct sequence -> err pulses once, err_cnt=1, locked stays 1, frame_cnt keeps counting.
- Lock, then feed 001,001 where 011,100 are expected (MAX_MISS=2) -> two err pulses, err_cnt=2, locked=0 after the second edge, state HUNT with run=1. Relocks 3 codes later (after 4 correct codes in total).
- Lock, then q=000 -> locked=0 next edge, err=0. Restart at 100,010,001,011 -> relocks with phase=1, showing mid-sequence entry works.
- Drive the illegal code 110 for 300 cycles with CNT_W=8 -> err_cnt saturates at 255. A clr pulse coincident with an error sets err_cnt=0.
- Lock, then assert rst_n=0 asynchronously between edges -> all outputs 0 immediately, without waiting for a clock edge. After release, re-lock needs a fresh 4 correct codes.

Source files
------------

// File: rtl/pattern_checker.sv
// Checks a 001/011/100/010 repeating pattern stream: finds its phase, locks after a
// run of correct codes, and flags/counts sequence errors and completed frames.
module pattern_checker #(
    parameter int unsigned LOCK_LEN = 4,
    parameter int unsigned MAX_MISS = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       q,
    input  logic             clr,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned RUN_W  = 4;
    localparam int unsigned MISS_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state;
    logic [RUN_W-1:0]  run;
    logic [MISS_W-1:0] miss;
    logic [1:0]        exp;

    logic              q_idle;
    logic              q_legal;
    logic [1:0]        q_phase;
    logic [2:0]        exp_code;
    logic              q_match;
    logic [RUN_W-1:0]  run_inc;
    logic [MISS_W-1:0] miss_inc;
    logic              err_ev;
    logic              frame_ev;

    // Classify the sampled code and map it to its phase.
    always_comb begin
        q_idle  = (q == 3'b000);
        q_legal = 1'b1;
        q_phase = 2'd0;
        case (q)
            3'b001:  q_phase = 2'd0;
            3'b011:  q_phase = 2'd1;
            3'b100:  q_phase = 2'd2;
            3'b010:  q_phase = 2'd3;
            default: q_legal = 1'b0;
        endcase
    end

    // Code the stream should carry this cycle.
    always_comb begin
        exp_code = 3'b001;
        case (exp)
            2'd0: exp_code = 3'b001;
            2'd1: exp_code = 3'b011;
            2'd2: exp_code = 3'b100;
            2'd3: exp_code = 3'b010;
            default: exp_code = 3'b001;
        endcase
        q_match  = (q == exp_code);
        run_inc  = run + RUN_W'(1);
        miss_inc = miss + MISS_W'(1);
    end

    // A HUNT with run=0 (left LOCKED on an illegal code) seeds from the next legal code silently.
    always_comb begin
        err_ev   = 1'b0;
        frame_ev = 1'b0;
        case (state)
            IDLE:    err_ev = !q_idle && !q_legal;
            HUNT:    err_ev = (!q_idle && !q_legal) || (q_legal && (run != '0) && !q_match);
            LOCKED: begin
                err_ev   = !q_idle && !q_match;
                frame_ev = q_match && (q == 3'b010);
            end
            default: err_ev = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            locked <= 1'b0;
            phase  <= 2'd0;
            err    <= 1'b0;
            run    <= '0;
            miss   <= '0;
            exp    <= 2'd0;
        end else begin
            err <= err_ev;
            if (q_legal) begin
                phase <= q_phase;
            end
            case (state)
                IDLE: begin
                    if (q_legal) begin
                        state <= HUNT;
                        run   <= RUN_W'(1);
                        exp   <= q_phase + 2'd1;
                    end
                end
                HUNT: begin
                    if (!q_legal) begin
                        state <= IDLE;
                        run   <= '0;
                    end else if ((run != '0) && q_match) begin
                        run <= run_inc;
                        exp <= exp + 2'd1;
                        if (run_inc == RUN_W'(LOCK_LEN)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            miss   <= '0;
                        end
                    end else begin
                        run <= RUN_W'(1);
                        exp <= q_phase + 2'd1;
                    end
                end
                LOCKED: begin
                    if (q_idle) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                        run    <= '0;
                        miss   <= '0;
                    end else if (q_match) begin
                        miss <= '0;
                        exp  <= exp + 2'd1;
                    end else if (miss_inc == MISS_W'(MAX_MISS)) begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        miss   <= '0;
                        run    <= q_legal ? RUN_W'(1) : RUN_W'(0);
                        exp    <= q_legal ? (q_phase + 2'd1) : (exp + 2'd1);
                    end else begin
                        miss <= miss_inc;
                        exp  <= exp + 2'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Error counter saturates; frame counter wraps; clr wins over both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt   <= '0;
            frame_cnt <= '0;
        end else if (clr) begin
            err_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            if (err_ev && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (frame_ev) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pattern_checker.sv
// Directed-vector scoreboard bench for pattern_checker: the driver queues hand-computed
// expected outputs per cycle, a monitor pops and compares them on the falling edge.
module tb_pattern_checker;

    typedef struct packed {
        logic       locked;
        logic [1:0] phase;
        logic       err;
        logic [7:0] err_cnt;
        logic [7:0] frame_cnt;
    } resp_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] q;
    logic       clr;
    logic       locked;
    logic [1:0] phase;
    logic       err;
    logic [7:0] err_cnt;
    logic [7:0] frame_cnt;

    resp_t exp_q[$];
    string tag_q[$];
    int    n_vec;
    int    n_bad;

    pattern_checker #(.LOCK_LEN(4), .MAX_MISS(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .q         (q),
        .clr       (clr),
        .locked    (locked),
        .phase     (phase),
        .err       (err),
        .err_cnt   (err_cnt),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic resp_t actual();
        resp_t r;
        r.locked    = locked;
        r.phase     = phase;
        r.err       = err;
        r.err_cnt   = err_cnt;
        r.frame_cnt = frame_cnt;
        return r;
    endfunction

    task automatic compare(input string tag, input resp_t act, input resp_t want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got locked=%0b phase=%0d err=%0b err_cnt=%0d frame_cnt=%0d, required locked=%0b phase=%0d err=%0b err_cnt=%0d frame_cnt=%0d",
                     tag, act.locked, act.phase, act.err, act.err_cnt, act.frame_cnt,
                     want.locked, want.phase, want.err, want.err_cnt, want.frame_cnt);
        end
    endtask

    // Monitor: outputs settle after the rising edge, so check on the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            compare(tag_q.pop_front(), actual(), exp_q.pop_front());
        end
    end

    task automatic step(input string tag, input logic [2:0] qv, input logic clrv,
                        input logic l, input logic [1:0] ph, input logic e,
                        input int ec, input int fc);
        resp_t r;
        @(negedge clk);
        q   = qv;
        clr = clrv;
        @(posedge clk);
        #1;
        r.locked    = l;
        r.phase     = ph;
        r.err       = e;
        r.err_cnt   = 8'(ec);
        r.frame_cnt = 8'(fc);
        exp_q.push_back(r);
        tag_q.push_back(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        resp_t zero;
        n_vec = 0;
        n_bad = 0;
        zero  = '0;
        q     = 3'b000;
        clr   = 1'b0;
        rst_n = 1'b0;
        #23;
        compare("reset_state", actual(), zero);
        rst_n = 1'b1;

        // Clean lock from idle, then one full frame while locked
        step("idle0", 3'b000, 0, 0, 0, 0, 0, 0);
        step("idle1", 3'b000, 0, 0, 0, 0, 0, 0);
        step("idle2", 3'b000, 0, 0, 0, 0, 0, 0);
        step("a_001", 3'b001, 0, 0, 0, 0, 0, 0);
        step("a_011", 3'b011, 0, 0, 1, 0, 0, 0);
        step("a_100", 3'b100, 0, 0, 2, 0, 0, 0);
        step("a_lock", 3'b010, 0, 1, 3, 0, 0, 0);
        step("a_001b", 3'b001, 0, 1, 0, 0, 0, 0);
        step("a_011b", 3'b011, 0, 1, 1, 0, 0, 0);
        step("a_100b", 3'b100, 0, 1, 2, 0, 0, 0);
        step("a_frame", 3'b010, 0, 1, 3, 0, 0, 1);

        // Single illegal code while locked: flywheel keeps lock
        step("b_001", 3'b001, 0, 1, 0, 0, 0, 1);
        step("b_011", 3'b011, 0, 1, 1, 0, 0, 1);
        step("b_111", 3'b111, 0, 1, 1, 1, 1, 1);
        step("b_frame", 3'b010, 0, 1, 3, 0, 1, 2);
        step("b_001b", 3'b001, 0, 1, 0, 0, 1, 2);

        // Two legal mismatches drop lock; relock three codes later
        step("c_miss1", 3'b001, 0, 1, 0, 1, 2, 2);
        step("c_miss2", 3'b001, 0, 0, 0, 1, 3, 2);
        step("c_011", 3'b011, 0, 0, 1, 0, 3, 2);
        step("c_100", 3'b100, 0, 0, 2, 0, 3, 2);
        step("c_relock", 3'b010, 0, 1, 3, 0, 3, 2);
        step("c_001", 3'b001, 0, 1, 0, 0, 3, 2);

        // Idle is a clean stop; mid-sequence restart locks at phase 1
        step("d_stop", 3'b000, 0, 0, 0, 0, 3, 2);
        step("d_100", 3'b100, 0, 0, 2, 0, 3, 2);
        step("d_010", 3'b010, 0, 0, 3, 0, 3, 2);
        step("d_001", 3'b001, 0, 0, 0, 0, 3, 2);
        step("d_lock", 3'b011, 0, 1, 1, 0, 3, 2);
        step("d_100b", 3'b100, 0, 1, 2, 0, 3, 2);
        step("d_frame", 3'b010, 0, 1, 3, 0, 3, 3);
        step("d_clr", 3'b001, 1, 1, 0, 0, 0, 0);

        // Illegal code flood saturates err_cnt; clr beats a coincident error
        step("e_stop", 3'b000, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            step("e_sat", 3'b110, 0, 0, 0, 1, (i + 1 > 255) ? 255 : i + 1, 0);
        end
        step("e_clr", 3'b110, 1, 0, 0, 1, 0, 0);
        step("e_after", 3'b110, 0, 0, 0, 1, 1, 0);
        step("e_idle", 3'b000, 0, 0, 0, 0, 1, 0);

        // Lock, then asynchronous reset between edges
        step("f_001", 3'b001, 0, 0, 0, 0, 1, 0);
        step("f_011", 3'b011, 0, 0, 1, 0, 1, 0);
        step("f_100", 3'b100, 0, 0, 2, 0, 1, 0);
        step("f_lock", 3'b010, 0, 1, 3, 0, 1, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compare("async_reset", actual(), zero);
        #4;
        rst_n = 1'b1;
        step("g_001", 3'b001, 0, 0, 0, 0, 0, 0);
        step("g_011", 3'b011, 0, 0, 1, 0, 0, 0);
        step("g_100", 3'b100, 0, 0, 2, 0, 0, 0);
        step("g_lock", 3'b010, 0, 1, 3, 0, 0, 0);

        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
